axi_2_mem_core: RTL and testbench
=================================

AXI_2_MEM_CORE -- requirements
Module: axi_2_mem_core

Interface
REQ-001 SHALL have parameter MEM_ADDRW, default 32, address width.
REQ-002 SHALL have parameter MEM_DATAW, default 32, data width.
REQ-003 SHALL have parameter MEM_STRBW, default MEM_DATAW/8, byte-enable width.
REQ-004 SHALL have type parameters axi_req_t and axi_resp_t, AXI4 request/response structs with MEM_ADDRW-bit address, MEM_DATAW-bit data and 8-bit len.
REQ-005 SHALL have port clk_i, in, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i, in, 1, reset, synchronous and active-high.
REQ-007 SHALL have port axi_req_i, in, axi_req_t, AXI request from the upstream OBI-to-AXI bridge.
REQ-008 SHALL have port axi_resp_o, out, axi_resp_t, AXI response to the bridge.
REQ-009 SHALL have port mem_req_o, out, 1, memory request valid.
REQ-010 SHALL have port mem_we_o, out, 1, memory write enable.
REQ-011 SHALL have port mem_addr_o, out, MEM_ADDRW, memory address.
REQ-012 SHALL have port mem_wdata_o, out, MEM_DATAW, memory write data.
REQ-013 SHALL have port mem_be_o, out, MEM_STRBW, memory byte enable.
REQ-014 SHALL have port mem_gnt_i, in, 1, memory grant.
REQ-015 SHALL have port mem_rvalid_i, in, 1, memory response valid; one per granted request, reads and writes.
REQ-016 SHALL have port mem_rdata_i, in, MEM_DATAW, memory read data, valid with mem_rvalid_i.

Function
REQ-017 SHALL implement the FSM IDLE, WR_DATA, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_RESP, RD_ERR.
REQ-018 In IDLE: aw_ready=1 and ar_ready=!aw_valid. A write wins when aw_valid and ar_valid are both high in the same cycle.
REQ-019 On an AW handshake the FSM SHALL capture addr, id and len, then go to WR_DATA.
REQ-020 In WR_DATA: w_ready=1. On each W handshake it SHALL capture data and strb. Exit on the beat with w.last=1: to WR_REQ if captured len==0, otherwise to WR_RESP with resp=SLVERR and no memory access.
REQ-021 In WR_REQ: mem_req_o=1 and mem_we_o=1, with the captured addr, data and strb held stable until mem_gnt_i. The gnt cycle SHALL go to WR_WAIT.
REQ-022 In WR_WAIT: exit on mem_rvalid_i to WR_RESP with resp=OKAY.
REQ-023 In WR_RESP: b_valid=1, b.id=captured id, b.resp held until b_ready; then go to IDLE.
REQ-024 On an AR handshake the FSM SHALL capture addr, id and len: len==0 goes to RD_REQ, len>0 goes to RD_ERR.
REQ-025 In RD_REQ: mem_req_o=1 and mem_we_o=0, held until mem_gnt_i, then go to RD_WAIT.
REQ-026 In RD_WAIT: on mem_rvalid_i, capture mem_rdata_i and go to RD_RESP.
REQ-027 In RD_RESP: r_valid=1, r.data=captured data, r.id=id, r.resp=OKAY, r.last=1, held until r_ready; then go to IDLE.
REQ-028 In RD_ERR: emit len+1 beats with r.data=0 and resp=SLVERR, using an 8-bit beat counter. r.last=1 only on beat len. The block SHALL return to IDLE after the last handshake, with no memory access.
REQ-029 Only one transaction SHALL be outstanding. aw_ready, w_ready and ar_ready SHALL be 0 outside the states above.
REQ-030 Best-case latency (mem_gnt_i in the request cycle, mem_rvalid_i the next cycle):
- Read: AR handshake cycle 0, mem_req_o cycle 1, r_valid cycle 3.
- Write: AW handshake cycle 0, W handshake cycle 1, mem_req_o cycle 2, b_valid cycle 4.
REQ-031 mem_addr_o SHALL carry the AXI address unmodified; no alignment or translation.
REQ-032 W beats arriving before the AW handshake SHALL be stalled (w_ready=0).
REQ-033 mem_rvalid_i outside WR_WAIT and RD_WAIT SHALL be ignored.
REQ-034 r_valid, once high, SHALL hold its payload stable until r_ready; the same applies to b_valid until b_ready.

Reset
REQ-035 While rst_i is high at a rising edge, state SHALL become IDLE and the beat counter 0.
REQ-036 Reset output values: mem_req_o=0, mem_we_o=0, b_valid=0, r_valid=0, w_ready=0, aw_ready=1, ar_ready=1, and all data/address/id registers 0.
REQ-037 Reset asserted mid-transaction SHALL abort it with no response. A late mem_rvalid_i after reset SHALL be ignored.

Verification
REQ-038 Single read: AR addr=0xAB id=3 len=0, mem_gnt_i immediate, mem_rdata_i=0x45 -> mem_req_o=1, mem_we_o=0, mem_addr_o=0xAB; then r_valid with data=0x45, id=3, OKAY, last=1, 3 cycles after the AR handshake.
REQ-039 Single write: AW addr=0xAB len=0, W data=0x69 strb=0xF last=1 -> mem_we_o=1, mem_wdata_o=0x69, mem_be_o=0xF; then b_valid with OKAY, held across 3 cycles of b_ready=0.
REQ-040 Simultaneous AW and AR in IDLE -> write completes first with ar_ready=0; read is accepted in IDLE afterwards.
REQ-041 Burst reject:
- AR len=3 -> 4 beats of SLVERR with data 0 and last only on beat 4; mem_req_o stays 0.
- AW len=1 with 2 W beats -> one B with SLVERR.
REQ-042 Backpressure and reset: mem_gnt_i withheld 5 cycles -> request held stable. rst_i pulsed in RD_WAIT -> IDLE with reset outputs, and a subsequent mem_rvalid_i produces no r_valid.

Source files
------------

// File: rtl/axi_2_mem_core.sv
// AXI4 slave to single-port memory adapter.
// One transaction in flight; bursts are rejected with SLVERR.
package axi_2_mem_pkg;
  localparam int AXI_AW = 32;
  localparam int AXI_DW = 32;
  localparam int AXI_IW = 4;
  localparam int AXI_SW = AXI_DW / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_AW-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } axi_ax_t;

  typedef struct packed {
    logic [AXI_DW-1:0] data;
    logic [AXI_SW-1:0] strb;
    logic              last;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [1:0]        resp;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic [AXI_DW-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_resp_t;
endpackage

module axi_2_mem_core
  import axi_2_mem_pkg::*;
#(
  parameter int  MEM_ADDRW  = 32,
  parameter int  MEM_DATAW  = 32,
  parameter int  MEM_STRBW  = MEM_DATAW / 8,
  parameter type axi_req_t  = axi_2_mem_pkg::axi_req_t,
  parameter type axi_resp_t = axi_2_mem_pkg::axi_resp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  axi_req_t             axi_req_i,
  output axi_resp_t            axi_resp_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [MEM_ADDRW-1:0] mem_addr_o,
  output logic [MEM_DATAW-1:0] mem_wdata_o,
  output logic [MEM_STRBW-1:0] mem_be_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [MEM_DATAW-1:0] mem_rdata_i
);

  localparam int IDW = $bits(axi_req_i.aw.id);

  typedef enum logic [3:0] {
    IDLE,
    WR_DATA,
    WR_REQ,
    WR_WAIT,
    WR_RESP,
    RD_REQ,
    RD_WAIT,
    RD_RESP,
    RD_ERR
  } state_e;

  state_e               state_q, state_d;
  logic [MEM_ADDRW-1:0] addr_q, addr_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [MEM_DATAW-1:0] wdata_q, wdata_d;
  logic [MEM_STRBW-1:0] strb_q, strb_d;
  logic [MEM_DATAW-1:0] rdata_q, rdata_d;
  logic [1:0]           resp_q, resp_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    unique case (state_q)
      IDLE: begin
        // aw_ready is always high here, so AW wins any tie
        if (axi_req_i.aw_valid) begin
          addr_d  = axi_req_i.aw.addr;
          id_d    = axi_req_i.aw.id;
          len_d   = axi_req_i.aw.len;
          state_d = WR_DATA;
        end else if (axi_req_i.ar_valid) begin
          addr_d  = axi_req_i.ar.addr;
          id_d    = axi_req_i.ar.id;
          len_d   = axi_req_i.ar.len;
          cnt_d   = '0;
          state_d = (axi_req_i.ar.len == 8'd0) ? RD_REQ : RD_ERR;
        end
      end
      WR_DATA: begin
        if (axi_req_i.w_valid) begin
          wdata_d = axi_req_i.w.data;
          strb_d  = axi_req_i.w.strb;
          if (axi_req_i.w.last) begin
            if (len_q == 8'd0) begin
              state_d = WR_REQ;
            end else begin
              resp_d  = RESP_SLVERR;
              state_d = WR_RESP;
            end
          end
        end
      end
      WR_REQ: begin
        if (mem_gnt_i) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (mem_rvalid_i) begin
          resp_d  = RESP_OKAY;
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (axi_req_i.b_ready) state_d = IDLE;
      end
      RD_REQ: begin
        if (mem_gnt_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid_i) begin
          rdata_d = mem_rdata_i;
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (axi_req_i.r_ready) state_d = IDLE;
      end
      RD_ERR: begin
        if (axi_req_i.r_ready) begin
          if (cnt_q == len_q) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    axi_resp_o = '0;
    unique case (state_q)
      IDLE: begin
        axi_resp_o.aw_ready = 1'b1;
        axi_resp_o.ar_ready = ~axi_req_i.aw_valid;
      end
      WR_DATA: axi_resp_o.w_ready = 1'b1;
      WR_RESP: begin
        axi_resp_o.b_valid = 1'b1;
        axi_resp_o.b.id    = id_q;
        axi_resp_o.b.resp  = resp_q;
      end
      RD_RESP: begin
        axi_resp_o.r_valid = 1'b1;
        axi_resp_o.r.id    = id_q;
        axi_resp_o.r.data  = rdata_q;
        axi_resp_o.r.resp  = RESP_OKAY;
        axi_resp_o.r.last  = 1'b1;
      end
      RD_ERR: begin
        axi_resp_o.r_valid = 1'b1;
        axi_resp_o.r.id    = id_q;
        axi_resp_o.r.data  = '0;
        axi_resp_o.r.resp  = RESP_SLVERR;
        axi_resp_o.r.last  = (cnt_q == len_q);
      end
      default: ;
    endcase
  end

  assign mem_req_o   = (state_q == WR_REQ) || (state_q == RD_REQ);
  assign mem_we_o    = (state_q == WR_REQ);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = strb_q;

endmodule

// File: tb/tb_axi_2_mem_core.sv
// Bench for axi_2_mem_core: directed scenarios plus a
// randomized mix against a transaction-level memory model.
module tb_axi_2_mem_core;
  import axi_2_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  axi_req_t    req;
  axi_resp_t   rsp;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  axi_2_mem_core dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .axi_req_i    (req),
    .axi_resp_o   (rsp),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_be_o     (mem_be),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_val(logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o,
                                        logic [31:0] d,
                                        logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) o[8*b +: 8] = d[8*b +: 8];
    return o;
  endfunction

  // memory seen by the DUT, updated from its own outputs
  logic [31:0] mem_arr [logic [31:0]];
  // reference memory, updated from the AXI stimulus
  logic [31:0] ref_arr [logic [31:0]];

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_arr.exists(a) ? ref_arr[a] : init_val(a);
  endfunction

  int          gnt_lat = 0;
  bit          rv_en = 1'b1;
  int          inj_req = 0;
  int          inj_done = 0;
  int          wait_c = 0;
  int          n_gnt = 0;
  int          n_req_cyc = 0;
  bit          pend = 1'b0;
  logic        pend_we;
  logic [31:0] pend_addr, pend_wdata;
  logic [3:0]  pend_be;
  int          gnt_cyc;
  logic        gnt_we;
  logic [31:0] gnt_addr, gnt_wdata;
  logic [3:0]  gnt_be;

  initial begin
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
  end

  // memory responder: grant after gnt_lat waiting cycles,
  // response valid on the cycle after the grant
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    if (pend && rv_en) begin
      mem_rvalid = 1'b1;
      if (pend_we)
        mem_arr[pend_addr] = merge(mem_rd(pend_addr),
                                   pend_wdata, pend_be);
      else
        mem_rdata = mem_rd(pend_addr);
    end
    if (inj_req != inj_done) begin
      mem_rvalid = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      inj_done = inj_req;
    end
    pend = 1'b0;
    mem_gnt = 1'b0;
    if (mem_req === 1'b1) begin
      n_req_cyc++;
      if (wait_c >= gnt_lat) begin
        mem_gnt = 1'b1;
        n_gnt++;
        pend = 1'b1;
        pend_we = mem_we;
        pend_addr = mem_addr;
        pend_wdata = mem_wdata;
        pend_be = mem_be;
        gnt_cyc = cyc;
        gnt_we = mem_we;
        gnt_addr = mem_addr;
        gnt_wdata = mem_wdata;
        gnt_be = mem_be;
        wait_c = 0;
      end else begin
        wait_c++;
      end
    end
  end

  logic [31:0] rd_q[$];
  logic [1:0]  rr_q[$];
  logic        rl_q[$];
  logic [3:0]  ri_q[$];
  int          r_first;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  int          b_first;

  task automatic do_ar(input logic [31:0] a, input logic [3:0] id,
                       input logic [7:0] len, output int hc);
    hc = -1;
    @(negedge clk);
    req.ar.addr = a;
    req.ar.id = id;
    req.ar.len = len;
    req.ar_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (rsp.ar_ready) begin
        hc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (hc < 0) begin
      checks++;
      errors++;
      $display("FAIL ar_timeout got none exp handshake");
    end
    @(posedge clk);
    #1 req.ar_valid = 1'b0;
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [3:0] id,
                       input logic [7:0] len, output int hc);
    hc = -1;
    @(negedge clk);
    req.aw.addr = a;
    req.aw.id = id;
    req.aw.len = len;
    req.aw_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (rsp.aw_ready) begin
        hc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (hc < 0) begin
      checks++;
      errors++;
      $display("FAIL aw_timeout got none exp handshake");
    end
    @(posedge clk);
    #1 req.aw_valid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] be,
                      input logic last, output int hc);
    hc = -1;
    @(negedge clk);
    req.w.data = d;
    req.w.strb = be;
    req.w.last = last;
    req.w_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (rsp.w_ready) begin
        hc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (hc < 0) begin
      checks++;
      errors++;
      $display("FAIL w_timeout got none exp handshake");
    end
    @(posedge clk);
    #1 req.w_valid = 1'b0;
  endtask

  task automatic get_r(input int dly);
    int  d;
    bit  done;
    bit  have;
    logic [$bits(axi_r_t)-1:0] held;
    rd_q.delete();
    rr_q.delete();
    rl_q.delete();
    ri_q.delete();
    r_first = -1;
    d = dly;
    done = 1'b0;
    have = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (rsp.r_valid) begin
        if (r_first < 0) r_first = cyc;
        if (have) begin
          checks++;
          if (rsp.r !== held) begin
            errors++;
            $display("FAIL r_stable got %h exp %h", rsp.r, held);
          end
        end
        held = rsp.r;
        have = 1'b1;
        if (d > 0) begin
          d--;
          req.r_ready = 1'b0;
        end else begin
          req.r_ready = 1'b1;
          rd_q.push_back(rsp.r.data);
          rr_q.push_back(rsp.r.resp);
          rl_q.push_back(rsp.r.last);
          ri_q.push_back(rsp.r.id);
          if (rsp.r.last) done = 1'b1;
          d = dly;
          have = 1'b0;
        end
      end else begin
        req.r_ready = 1'b0;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL r_timeout got %0d beats exp last", rd_q.size());
    end
    @(posedge clk);
    #1 req.r_ready = 1'b0;
  endtask

  task automatic get_b(input int dly);
    int  d;
    bit  done;
    bit  have;
    logic [$bits(axi_b_t)-1:0] held;
    b_first = -1;
    d = dly;
    done = 1'b0;
    have = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (rsp.b_valid) begin
        if (b_first < 0) b_first = cyc;
        if (have) begin
          checks++;
          if (rsp.b !== held) begin
            errors++;
            $display("FAIL b_stable got %h exp %h", rsp.b, held);
          end
        end
        held = rsp.b;
        have = 1'b1;
        if (d > 0) begin
          d--;
          req.b_ready = 1'b0;
        end else begin
          req.b_ready = 1'b1;
          b_id = rsp.b.id;
          b_resp = rsp.b.resp;
          done = 1'b1;
        end
      end else begin
        req.b_ready = 1'b0;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL b_timeout got none exp b_valid");
    end
    @(posedge clk);
    #1 req.b_ready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({mem_req, mem_we, rsp.b_valid, rsp.r_valid,
         rsp.w_ready, rsp.aw_ready, rsp.ar_ready} !== 7'b0000011) begin
      errors++;
      $display("FAIL %s_ctrl got %b exp 0000011", tag,
               {mem_req, mem_we, rsp.b_valid, rsp.r_valid,
                rsp.w_ready, rsp.aw_ready, rsp.ar_ready});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_be} !== 68'd0) begin
      errors++;
      $display("FAIL %s_regs got %h %h %h exp 0", tag,
               mem_addr, mem_wdata, mem_be);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_idle_outputs("reset");
  endtask

  task automatic test_single_read();
    int hc;
    mem_arr[32'hAB] = 32'h45;
    ref_arr[32'hAB] = 32'h45;
    gnt_lat = 0;
    do_ar(32'hAB, 4'd3, 8'd0, hc);
    get_r(0);
    checks++;
    if ({gnt_cyc, gnt_we, gnt_addr} !== {hc + 1, 1'b0, 32'hAB}) begin
      errors++;
      $display("FAIL rd_memreq got cyc %0d we %b addr %h exp cyc %0d we 0 addr ab",
               gnt_cyc - hc, gnt_we, gnt_addr, 1);
    end
    checks++;
    if (r_first - hc !== 3) begin
      errors++;
      $display("FAIL rd_latency got %0d exp 3", r_first - hc);
    end
    checks++;
    if (rd_q.size() != 1 ||
        {rd_q[0], ri_q[0], rr_q[0], rl_q[0]} !==
        {32'h45, 4'd3, RESP_OKAY, 1'b1}) begin
      errors++;
      $display("FAIL rd_payload got n=%0d %h exp n=1 data 45 id 3 okay last",
               rd_q.size(), rd_q.size() ? rd_q[0] : 32'h0);
    end
  endtask

  task automatic test_single_write();
    int ah, wh;
    gnt_lat = 0;
    do_aw(32'hAB, 4'd5, 8'd0, ah);
    do_w(32'h69, 4'hF, 1'b1, wh);
    get_b(3);
    ref_arr[32'hAB] = merge(ref_rd(32'hAB), 32'h69, 4'hF);
    checks++;
    if (wh - ah !== 1) begin
      errors++;
      $display("FAIL wr_w_cycle got %0d exp 1", wh - ah);
    end
    checks++;
    if ({gnt_cyc - ah, gnt_we, gnt_addr, gnt_wdata, gnt_be} !==
        {32'd2, 1'b1, 32'hAB, 32'h69, 4'hF}) begin
      errors++;
      $display("FAIL wr_memreq got cyc %0d we %b a %h d %h be %h exp 2 1 ab 69 f",
               gnt_cyc - ah, gnt_we, gnt_addr, gnt_wdata, gnt_be);
    end
    checks++;
    if (b_first - ah !== 4) begin
      errors++;
      $display("FAIL wr_latency got %0d exp 4", b_first - ah);
    end
    checks++;
    if ({b_id, b_resp} !== {4'd5, RESP_OKAY}) begin
      errors++;
      $display("FAIL wr_bresp got id %0d resp %0d exp id 5 resp 0", b_id, b_resp);
    end
  endtask

  task automatic test_simultaneous();
    int ah, wh, rh;
    logic [31:0] exp;
    gnt_lat = 0;
    @(negedge clk);
    req.aw.addr = 32'h100;
    req.aw.id = 4'd1;
    req.aw.len = 8'd0;
    req.aw_valid = 1'b1;
    req.ar.addr = 32'h100;
    req.ar.id = 4'd2;
    req.ar.len = 8'd0;
    req.ar_valid = 1'b1;
    #1;
    ah = cyc;
    checks++;
    if ({rsp.aw_ready, rsp.ar_ready} !== 2'b10) begin
      errors++;
      $display("FAIL tie_ready got %b exp 10", {rsp.aw_ready, rsp.ar_ready});
    end
    @(posedge clk);
    #1 req.aw_valid = 1'b0;
    do_w(32'hCAFE_F00D, 4'b0011, 1'b1, wh);
    @(negedge clk);
    #1;
    checks++;
    if (rsp.ar_ready !== 1'b0) begin
      errors++;
      $display("FAIL tie_ar_blocked got %b exp 0", rsp.ar_ready);
    end
    get_b(0);
    ref_arr[32'h100] = merge(ref_rd(32'h100), 32'hCAFE_F00D, 4'b0011);
    checks++;
    if ({b_id, b_resp, gnt_we} !== {4'd1, RESP_OKAY, 1'b1}) begin
      errors++;
      $display("FAIL tie_write got id %0d resp %0d we %b exp 1 0 1",
               b_id, b_resp, gnt_we);
    end
    do_ar(32'h100, 4'd2, 8'd0, rh);
    get_r(1);
    exp = ref_rd(32'h100);
    checks++;
    if (rd_q.size() != 1 || rd_q[0] !== exp || ri_q[0] !== 4'd2 ||
        r_first <= b_first) begin
      errors++;
      $display("FAIL tie_read got %h exp %h", rd_q.size() ? rd_q[0] : 32'h0, exp);
    end
  endtask

  task automatic test_burst_read();
    int hc, n0;
    n0 = n_req_cyc;
    do_ar(32'h40, 4'd7, 8'd3, hc);
    get_r(1);
    checks++;
    if (rd_q.size() != 4) begin
      errors++;
      $display("FAIL brd_beats got %0d exp 4", rd_q.size());
    end
    for (int i = 0; i < rd_q.size(); i++) begin
      checks++;
      if ({rd_q[i], rr_q[i], rl_q[i], ri_q[i]} !==
          {32'd0, RESP_SLVERR, (i == 3), 4'd7}) begin
        errors++;
        $display("FAIL brd_beat%0d got %h %0d %b %0d exp 0 2 %b 7",
                 i, rd_q[i], rr_q[i], rl_q[i], ri_q[i], (i == 3));
      end
    end
    checks++;
    if (n_req_cyc !== n0) begin
      errors++;
      $display("FAIL brd_nomem got %0d exp 0", n_req_cyc - n0);
    end
  endtask

  task automatic test_burst_write();
    int hc, n0;
    n0 = n_req_cyc;
    do_aw(32'h44, 4'd6, 8'd1, hc);
    do_w(32'h1111_1111, 4'hF, 1'b0, hc);
    do_w(32'h2222_2222, 4'hF, 1'b1, hc);
    get_b(0);
    checks++;
    if ({b_id, b_resp} !== {4'd6, RESP_SLVERR}) begin
      errors++;
      $display("FAIL bwr_bresp got id %0d resp %0d exp 6 2", b_id, b_resp);
    end
    checks++;
    if (n_req_cyc !== n0) begin
      errors++;
      $display("FAIL bwr_nomem got %0d exp 0", n_req_cyc - n0);
    end
  endtask

  task automatic test_backpressure();
    int hc, nreq;
    bit got;
    gnt_lat = 5;
    nreq = 0;
    got = 1'b0;
    do_aw(32'h80, 4'd1, 8'd0, hc);
    do_w(32'h1234_5678, 4'b1010, 1'b1, hc);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      #1;
      if (mem_req) begin
        nreq++;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, mem_be} !==
            {1'b1, 32'h80, 32'h1234_5678, 4'b1010}) begin
          errors++;
          $display("FAIL bp_stable got %b %h %h %h exp 1 80 12345678 a",
                   mem_we, mem_addr, mem_wdata, mem_be);
        end
        if (mem_gnt) got = 1'b1;
      end
    end
    checks++;
    if (nreq !== 6) begin
      errors++;
      $display("FAIL bp_req_cycles got %0d exp 6", nreq);
    end
    gnt_lat = 0;
    get_b(0);
    ref_arr[32'h80] = merge(ref_rd(32'h80), 32'h1234_5678, 4'b1010);
    checks++;
    if (b_resp !== RESP_OKAY) begin
      errors++;
      $display("FAIL bp_bresp got %0d exp 0", b_resp);
    end
  endtask

  task automatic test_reset_mid();
    int hc;
    bit got;
    logic [31:0] exp;
    gnt_lat = 0;
    rv_en = 1'b0;
    got = 1'b0;
    do_ar(32'h20, 4'd2, 8'd0, hc);
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      #1;
      if (mem_gnt) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rst_gnt got none exp grant");
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rv_en = 1'b1;
    #1;
    check_idle_outputs("rstmid");
    inj_req++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({rsp.r_valid, rsp.b_valid, mem_req} !== 3'b000) begin
        errors++;
        $display("FAIL rst_late_rvalid got %b exp 000",
                 {rsp.r_valid, rsp.b_valid, mem_req});
      end
    end
    do_ar(32'h20, 4'd9, 8'd0, hc);
    get_r(0);
    exp = ref_rd(32'h20);
    checks++;
    if (rd_q.size() != 1 || rd_q[0] !== exp) begin
      errors++;
      $display("FAIL rst_recover got %h exp %h",
               rd_q.size() ? rd_q[0] : 32'h0, exp);
    end
  endtask

  task automatic test_random();
    int hc, kind, dly, g0, len;
    logic [31:0] a, d, exp;
    logic [3:0]  id, be;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 3);
      a = 32'h200 + ($urandom_range(0, 7) * 4);
      id = 4'($urandom_range(0, 15));
      gnt_lat = $urandom_range(0, 3);
      dly = $urandom_range(0, 2);
      g0 = n_gnt;
      case (kind)
        0: begin
          do_ar(a, id, 8'd0, hc);
          get_r(dly);
          exp = ref_rd(a);
          checks++;
          if (rd_q.size() != 1 ||
              {rd_q[0], ri_q[0], rr_q[0], rl_q[0]} !==
              {exp, id, RESP_OKAY, 1'b1} || n_gnt - g0 != 1) begin
            errors++;
            $display("FAIL rnd_read got %h exp %h addr %h",
                     rd_q.size() ? rd_q[0] : 32'h0, exp, a);
          end
        end
        1: begin
          d = $urandom;
          be = 4'($urandom_range(1, 15));
          do_aw(a, id, 8'd0, hc);
          do_w(d, be, 1'b1, hc);
          get_b(dly);
          ref_arr[a] = merge(ref_rd(a), d, be);
          checks++;
          if ({b_id, b_resp} !== {id, RESP_OKAY} || n_gnt - g0 != 1) begin
            errors++;
            $display("FAIL rnd_write got id %0d resp %0d exp %0d 0",
                     b_id, b_resp, id);
          end
        end
        2: begin
          len = $urandom_range(1, 5);
          do_ar(a, id, 8'(len), hc);
          get_r(dly);
          checks++;
          if (rd_q.size() != len + 1 || n_gnt != g0) begin
            errors++;
            $display("FAIL rnd_bread got %0d beats exp %0d",
                     rd_q.size(), len + 1);
          end else begin
            for (int i = 0; i <= len; i++) begin
              checks++;
              if ({rd_q[i], rr_q[i], rl_q[i], ri_q[i]} !==
                  {32'd0, RESP_SLVERR, (i == len), id}) begin
                errors++;
                $display("FAIL rnd_bbeat%0d got %h %0d %b exp 0 2 %b",
                         i, rd_q[i], rr_q[i], rl_q[i], (i == len));
              end
            end
          end
        end
        default: begin
          len = $urandom_range(1, 3);
          do_aw(a, id, 8'(len), hc);
          for (int i = 0; i <= len; i++)
            do_w($urandom, 4'hF, (i == len), hc);
          get_b(dly);
          checks++;
          if ({b_id, b_resp} !== {id, RESP_SLVERR} || n_gnt != g0) begin
            errors++;
            $display("FAIL rnd_bwrite got id %0d resp %0d exp %0d 2",
                     b_id, b_resp, id);
          end
        end
      endcase
    end
    gnt_lat = 0;
  endtask

  initial begin
    req = '0;
    rst = 1'b1;
    test_reset();
    test_single_read();
    test_single_write();
    test_simultaneous();
    test_burst_read();
    test_burst_write();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
